// File: rtl/naneye_line_encoder.sv
// naneye_line_encoder
//   Serialises one image line as a Manchester-coded bit stream. A line is a
//   preamble of SYNC_BITS ones, followed by C_COLUMNS frames. Each frame is a
//   start bit (1), D_WIDTH pixel bits sent MSB first, and a stop bit (0).
//   Every bit lasts 2*HALF_BIT_CYCLES clocks: a 1 is sent high-then-low and a
//   0 is sent low-then-high.
//
// Ports
//   CLOCK       in   sole clock, rising edge
//   RESET       in   asynchronous, active-low
//   LINE_START  in   one-cycle request to send a line (ignored unless idle)
//   PIX_DATA    in   pixel word, D_WIDTH bits
//   PIX_VALID   in   PIX_DATA valid
//   PIX_READY   out  word-fetch strobe; a word transfers on PIX_READY & PIX_VALID
//   TX_DATA     out  registered Manchester line
//   TX_ACTIVE   out  high while a line is on the wire
//   LINE_DONE   out  one-cycle pulse after the last stop bit
//   UNDERRUN    out  sticky: a word was missing in the current or last line
module naneye_line_encoder #(
    parameter int D_WIDTH         = 10,
    parameter int C_COLUMNS       = 320,
    parameter int HALF_BIT_CYCLES = 4,
    parameter int SYNC_BITS       = 24
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               LINE_START,
    input  logic [D_WIDTH-1:0] PIX_DATA,
    input  logic               PIX_VALID,
    output logic               PIX_READY,
    output logic               TX_DATA,
    output logic               TX_ACTIVE,
    output logic               LINE_DONE,
    output logic               UNDERRUN
);

    localparam int HW         = $clog2(HALF_BIT_CYCLES) + 1;
    localparam int CW         = $clog2(C_COLUMNS) + 1;
    localparam int FRAME_BITS = D_WIDTH + 2;
    localparam int BMAX       = (SYNC_BITS > FRAME_BITS) ? SYNC_BITS : FRAME_BITS;
    localparam int BW         = $clog2(BMAX) + 1;

    localparam logic [HW-1:0] HALF_LAST = HW'(HALF_BIT_CYCLES - 1);
    localparam logic [BW-1:0] SYNC_LAST = BW'(SYNC_BITS - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(D_WIDTH);
    localparam logic [BW-1:0] STOP_IDX  = BW'(D_WIDTH + 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(C_COLUMNS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        WORD,
        DONE
    } state_t;

    // All position registers describe the cycle currently shown on TX_DATA.
    state_t              state_q, state_d;
    logic [HW-1:0]       half_q, half_d;    // cycle within the half-bit
    logic                phase_q, phase_d;  // 0: first half, 1: second half
    logic [BW-1:0]       bit_q, bit_d;      // sync bit index, or frame bit index
    logic [CW-1:0]       col_q, col_d;
    logic [D_WIDTH-1:0]  shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                und_q, und_d;

    logic half_end;
    logic bit_end;
    logic fetch;

    assign half_end = (half_q == HALF_LAST);
    assign bit_end  = half_end && phase_q;

    // Fetch on the last cycle of the preamble and of every stop bit that is
    // followed by another word.
    always_comb begin
        fetch = 1'b0;
        if (bit_end) begin
            if (state_q == SYNC && bit_q == SYNC_LAST) begin
                fetch = 1'b1;
            end else if (state_q == WORD && bit_q == STOP_IDX && col_q != COL_LAST) begin
                fetch = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        col_d   = col_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        und_d   = und_q;

        // A missing word is sent as zero data bits inside a normal frame.
        if (fetch) begin
            shift_d = PIX_VALID ? PIX_DATA : '0;
            if (!PIX_VALID) begin
                und_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b0;
                if (LINE_START) begin
                    state_d = SYNC;
                    half_d  = '0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                    col_d   = '0;
                    und_d   = 1'b0;
                    tx_d    = 1'b1;  // first half of the first preamble 1
                end
            end

            SYNC, WORD: begin
                if (!half_end) begin
                    half_d = half_q + 1'b1;
                end else if (!phase_q) begin
                    // Mid-bit transition: the second half is the inverse.
                    half_d  = '0;
                    phase_d = 1'b1;
                    tx_d    = ~tx_q;
                end else begin
                    half_d  = '0;
                    phase_d = 1'b0;
                    if (state_q == SYNC) begin
                        if (bit_q == SYNC_LAST) begin
                            state_d = WORD;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                        tx_d = 1'b1;  // another preamble 1, or the start bit
                    end else if (bit_q == STOP_IDX) begin
                        if (col_q == COL_LAST) begin
                            state_d = DONE;
                            tx_d    = 1'b0;
                        end else begin
                            col_d = col_q + 1'b1;
                            bit_d = '0;
                            tx_d  = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                        if (bit_q == DATA_LAST) begin
                            tx_d = 1'b0;  // stop bit
                        end else if (bit_q == '0) begin
                            tx_d = shift_q[D_WIDTH-1];
                        end else begin
                            shift_d = shift_q << 1;
                            tx_d    = shift_d[D_WIDTH-1];
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                tx_d    = 1'b0;
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            half_q  <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
            col_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            col_q   <= col_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            und_q   <= und_d;
        end
    end

    assign PIX_READY = fetch;
    assign TX_DATA   = tx_q;
    assign TX_ACTIVE = (state_q == SYNC) || (state_q == WORD);
    assign LINE_DONE = (state_q == DONE);
    assign UNDERRUN  = und_q;

endmodule

// File: tb/tb_naneye_line_encoder.sv
module tb_naneye_line_encoder;

    localparam int D = 10;
    localparam int C = 2;
    localparam int S = 4;

    typedef struct packed {
        logic tx;
        logic act;
        logic rdy;
        logic done;
        logic und;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rstn;
    logic [1:0]        ls;
    logic [1:0]        pv;
    logic [1:0][D-1:0] pd;
    logic [1:0]        tx, act, rdy, done, und;

    // dut_a: HALF_BIT_CYCLES=2, dut_b: HALF_BIT_CYCLES=1
    naneye_line_encoder #(
        .D_WIDTH(D), .C_COLUMNS(C), .HALF_BIT_CYCLES(2), .SYNC_BITS(S)
    ) dut_a (
        .CLOCK(clk), .RESET(rstn[0]), .LINE_START(ls[0]),
        .PIX_DATA(pd[0]), .PIX_VALID(pv[0]), .PIX_READY(rdy[0]),
        .TX_DATA(tx[0]), .TX_ACTIVE(act[0]), .LINE_DONE(done[0]),
        .UNDERRUN(und[0])
    );

    naneye_line_encoder #(
        .D_WIDTH(D), .C_COLUMNS(C), .HALF_BIT_CYCLES(1), .SYNC_BITS(S)
    ) dut_b (
        .CLOCK(clk), .RESET(rstn[1]), .LINE_START(ls[1]),
        .PIX_DATA(pd[1]), .PIX_VALID(pv[1]), .PIX_READY(rdy[1]),
        .TX_DATA(tx[1]), .TX_ACTIVE(act[1]), .LINE_DONE(done[1]),
        .UNDERRUN(und[1])
    );

    int checks = 0;
    int errors = 0;

    exp_t qa[$];
    exp_t qb[$];
    logic und_l [2];
    int   cnt   [2];
    int   nrdy  [2];
    int   nline [2];
    logic [255:0] cap [2];

    function automatic void chk(input string nm, input int d,
                                input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s dut%0d got %h want %h at %0t", nm, d, a, e, $time);
        end
    endfunction

    function automatic void qpush(input int d, input exp_t e);
        if (d == 0) qa.push_back(e);
        else        qb.push_back(e);
    endfunction

    // Expected per-cycle outputs of one line, starting with the cycle after
    // LINE_START is sampled, built from the bit sequence of the line.
    function automatic void build(input int d, input int h,
                                  input logic [D-1:0] w0, input logic [D-1:0] w1,
                                  input logic v0, input logic v1);
        logic         bits[$];
        logic [D-1:0] w [2];
        logic         v [2];
        int           ro [2];
        exp_t         e;
        int           i;
        w[0] = w0; w[1] = w1; v[0] = v0; v[1] = v1;
        for (int s = 0; s < S; s++) bits.push_back(1'b1);
        for (int j = 0; j < C; j++) begin
            bits.push_back(1'b1);
            for (int b = D - 1; b >= 0; b--) bits.push_back(v[j] & w[j][b]);
            bits.push_back(1'b0);
            ro[j] = S * 2 * h - 1 + j * (D + 2) * 2 * h;
        end
        for (int n = 0; n < bits.size(); n++) begin
            for (int c = 0; c < 2 * h; c++) begin
                i      = n * 2 * h + c;
                e.tx   = (c < h) ? bits[n] : ~bits[n];
                e.act  = 1'b1;
                e.rdy  = (i == ro[0]) || (i == ro[1]);
                e.done = 1'b0;
                e.und  = (!v[0] && i > ro[0]) || (!v[1] && i > ro[1]);
                qpush(d, e);
            end
        end
        e = '{1'b0, 1'b0, 1'b0, 1'b1, !(v[0] && v[1])};
        qpush(d, e);
    endfunction

    // Compare process: every cycle, every DUT output against the model.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (d == 0 && qa.size() > 0) begin
                e = qa.pop_front();
                und_l[d] = e.und;
            end else if (d == 1 && qb.size() > 0) begin
                e = qb.pop_front();
                und_l[d] = e.und;
            end else begin
                e = '{1'b0, 1'b0, 1'b0, 1'b0, und_l[d]};
            end
            chk("outputs{tx,act,rdy,done,und}", d,
                64'({tx[d], act[d], rdy[d], done[d], und[d]}), 64'(e));

            if (!rstn[d]) begin
                cnt[d]  = 0;
                nrdy[d] = 0;
            end else begin
                if (act[d]) begin
                    if (cnt[d] < 256) cap[d][cnt[d]] = tx[d];
                    cnt[d]++;
                end
                if (rdy[d]) nrdy[d]++;
                if (done[d]) begin
                    chk("line_len", d, 64'(cnt[d]), (d == 0) ? 64'd112 : 64'd56);
                    chk("ready_pulses", d, 64'(nrdy[d]), 64'd2);
                    // Waveform pins: bit 1 = 0011, bit 0 = 1100 (oldest cycle in LSB).
                    if (d == 0 && nline[0] == 0) begin
                        chk("sync_pattern", d, 64'(cap[0][15:0]), 64'(16'h3333));
                        chk("word0_3ff", d, 64'(cap[0][63:16]),
                            64'({4'b1100, {10{4'b0011}}, 4'b0011}));
                        chk("word1_001", d, 64'(cap[0][111:64]),
                            64'({4'b1100, 4'b0011, {9{4'b1100}}, 4'b0011}));
                    end
                    if (d == 0 && nline[0] == 1) begin
                        chk("word1_underrun", d, 64'(cap[0][111:64]),
                            64'({4'b1100, {10{4'b1100}}, 4'b0011}));
                    end
                    nline[d]++;
                    cnt[d]  = 0;
                    nrdy[d] = 0;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called 1 time unit after a rising edge; returns likewise, in the cycle
    // right after LINE_DONE (or after reset release when aborting).
    task automatic run_line(input int d, input int h,
                            input logic [D-1:0] w0, input logic [D-1:0] w1,
                            input logic v0, input logic v1,
                            input logic ign, input int abort_at);
        int L;
        int ro0;
        L   = (S + C * (D + 2)) * 2 * h;
        ro0 = S * 2 * h - 1;
        ls[d] = 1'b1;
        @(posedge clk);
        #1;
        ls[d] = 1'b0;
        build(d, h, w0, w1, v0, v1);
        for (int i = 0; i <= L; i++) begin
            if (i == abort_at) begin
                rstn[d] = 1'b0;
                if (d == 0) qa.delete();
                else        qb.delete();
                und_l[d] = 1'b0;
                idle(3);
                rstn[d] = 1'b1;
                return;
            end
            pd[d] = (i <= ro0) ? w0 : w1;
            pv[d] = (i <= ro0) ? v0 : v1;
            ls[d] = ign && (i == 5 || i == L);
            @(posedge clk);
            #1;
        end
        ls[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            und_l[d] = 1'b0;
            cnt[d]   = 0;
            nrdy[d]  = 0;
            nline[d] = 0;
            cap[d]   = '0;
        end
        rstn = 2'b11;
        ls   = 2'b00;
        pv   = 2'b00;
        pd   = '0;
        #1;
        rstn = 2'b00;
        idle(2);
        rstn = 2'b11;
        for (int d = 0; d < 2; d++) begin
            chk("reset_state", d, 64'({tx[d], act[d], rdy[d], done[d], und[d]}), 64'd0);
        end
        idle(1);

        // Full line with words 0x3FF, 0x001 and LINE_START pulses mid-line and in DONE
        run_line(0, 2, 10'h3FF, 10'h001, 1'b1, 1'b1, 1'b1, -1);
        idle(3);
        // Second word missing
        run_line(0, 2, 10'h3FF, 10'h155, 1'b1, 1'b0, 1'b0, -1);
        idle(4);
        // Reset at cycle 50 of the line, then a full line
        run_line(0, 2, 10'h0F0, 10'h00F, 1'b1, 1'b1, 1'b0, 50);
        idle(2);
        run_line(0, 2, 10'h123, 10'h2CC, 1'b1, 1'b1, 1'b0, -1);
        idle(3);
        // First word missing
        run_line(0, 2, 10'h3FF, 10'h001, 1'b0, 1'b1, 1'b0, -1);
        idle(3);

        // HALF_BIT_CYCLES=1, back-to-back lines
        run_line(1, 1, 10'h3FF, 10'h001, 1'b1, 1'b1, 1'b0, -1);
        run_line(1, 1, 10'h3FF, 10'h001, 1'b1, 1'b1, 1'b0, -1);
        run_line(1, 1, 10'h2A5, 10'h15A, 1'b1, 1'b1, 1'b0, -1);
        idle(4);

        chk("lines_done_a", 0, 64'(nline[0]), 64'd4);
        chk("lines_done_b", 1, 64'(nline[1]), 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
